// File: rtl/bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor and adder).
package bit_serial_subtractor_pkg;

  // Default operand width and bit-counter width; 2**DefaultCw must exceed DefaultWidth.
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultCw    = 4;

  // Controller states; 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Difference bit and borrow-out of a single stage.
  always_comb begin
    d_o    = x_i ^ y_i ^ bin_i;
    bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
  end

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN, one bit per clock, LSB first.
// Operands load in parallel, shift through a 1-bit full subtractor and are
// reassembled into a registered parallel result with a done/busy handshake.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CW    = DefaultCw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             load,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] sreg_shift;

  full_subtractor u_fs (
    .x_i    (areg_q[0]),
    .y_i    (breg_q[0]),
    .bin_i  (borrow_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  // Result shift register with this cycle's difference bit entering at the MSB.
  always_comb begin
    sreg_shift = {fs_d, sreg_q[WIDTH-1:1]};
  end

  // State, datapath and result registers; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      areg_q   <= '0;
      breg_q   <= '0;
      sreg_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      sreg_q   <= sreg_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: operand capture, per-bit shift, and result commit on the last bit.
  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    sreg_d   = sreg_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          state_d  = StShift;
          areg_d   = a;
          breg_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          sreg_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        areg_d   = areg_q >> 1;
        breg_d   = breg_q >> 1;
        sreg_d   = sreg_shift;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          diff_d  = sreg_shift;
          bout_d  = fs_bout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    diff = diff_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH=8).
module tb_bit_serial_subtractor;

  logic       clk;
  logic       reset;
  logic [7:0] a, b;
  logic       bin;
  logic       load;
  logic [7:0] diff;
  logic       bout, busy, done;

  int errors = 0;
  int checks = 0;

  bit_serial_subtractor #(.WIDTH(8), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .load  (load),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse load with the given operands, then wait for done (bounded) and check
  // latency, busy duration and the result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input logic [7:0] ediff, input logic ebout, input int idx);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    a = 8'hA5; b = 8'h5A; bin = ~tbin;
    busy_cnt = 0;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk($sformatf("v%0d done_seen", idx), int'(seen), 1);
    chk($sformatf("v%0d latency", idx), lat, 8);
    chk($sformatf("v%0d busy_cycles", idx), busy_cnt, 8);
    chk($sformatf("v%0d diff", idx), int'(diff), int'(ediff));
    chk($sformatf("v%0d bout", idx), int'(bout), int'(ebout));
  endtask

  initial begin
    int done_cnt;
    int t1, t2;
    logic [7:0] d1, d2;
    bit got1, got2;

    vecs[0] = '{a: 8'd49,  b: 8'd37,  bin: 1'b0, exp_diff: 8'd12,  exp_bout: 1'b0};
    vecs[1] = '{a: 8'd37,  b: 8'd49,  bin: 1'b0, exp_diff: 8'd244, exp_bout: 1'b1};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   bin: 1'b1, exp_diff: 8'd255, exp_bout: 1'b1};
    vecs[3] = '{a: 8'd100, b: 8'd0,   bin: 1'b1, exp_diff: 8'd99,  exp_bout: 1'b0};
    vecs[4] = '{a: 8'd255, b: 8'd255, bin: 1'b0, exp_diff: 8'd0,   exp_bout: 1'b0};
    vecs[5] = '{a: 8'd0,   b: 8'd255, bin: 1'b0, exp_diff: 8'd1,   exp_bout: 1'b1};
    vecs[6] = '{a: 8'd128, b: 8'd1,   bin: 1'b1, exp_diff: 8'd126, exp_bout: 1'b0};
    vecs[7] = '{a: 8'd5,   b: 8'd5,   bin: 1'b1, exp_diff: 8'd255, exp_bout: 1'b1};
    vecs[8] = '{a: 8'd170, b: 8'd85,  bin: 1'b0, exp_diff: 8'd85,  exp_bout: 1'b0};

    reset = 1'b1; load = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset diff", int'(diff), 0);
    chk("reset bout", int'(bout), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout, i);
    end

    // Load while busy is ignored: 200-55 must finish untouched, single done pulse.
    @(negedge clk);
    a = 8'd200; b = 8'd55; bin = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd1; load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    done_cnt = 0;
    d1 = '0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        done_cnt++;
        d1 = diff;
        chk("busy-load bout", int'(bout), 0);
      end
      @(negedge clk);
    end
    chk("busy-load done pulses", done_cnt, 1);
    chk("busy-load diff", int'(d1), 145);

    // Back-to-back with load held: 255-255 then 10-3, done pulses 9 cycles apart.
    @(negedge clk);
    a = 8'd255; b = 8'd255; bin = 1'b0; load = 1'b1;
    @(negedge clk);
    a = 8'd10; b = 8'd3;
    got1 = 1'b0; got2 = 1'b0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (!got1) begin
          got1 = 1'b1; t1 = i; d1 = diff;
        end else if (!got2) begin
          got2 = 1'b1; t2 = i; d2 = diff;
        end
      end else if (got1) begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    chk("b2b first done", int'(got1), 1);
    chk("b2b second done", int'(got2), 1);
    chk("b2b spacing", t2 - t1, 9);
    chk("b2b diff1", int'(d1), 0);
    chk("b2b diff2", int'(d2), 7);

    // Asynchronous reset mid-operation clears everything immediately.
    @(negedge clk);
    a = 8'd49; b = 8'd37; bin = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", int'(busy), 1);
    chk("pre-reset diff held", int'(diff), 7);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", int'(busy), 0);
    chk("async reset done", int'(done), 0);
    chk("async reset diff", int'(diff), 0);
    chk("async reset bout", int'(bout), 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("no done after reset", done_cnt, 0);
    run_op(8'd5, 8'd2, 1'b0, 8'd3, 1'b0, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
